elevator_request_scheduler: RTL and testbench
=============================================

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Parameters
REQ-001 SHALL have parameter NUM_FLOORS, default 10: number of served floors (0..NUM_FLOORS-1), max 16.
REQ-002 SHALL have parameter DOOR_CYCLES, default 10000000: door-open dwell in clk cycles, 1..2^24-1.

Interface
REQ-003 SHALL have input clk, 1 bit: system clock, all state on rising edge.
REQ-004 SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have input call_req, NUM_FLOORS bits: bit n high for one or more cycles requests floor n.
REQ-006 SHALL have input current_floor, 4 bits: car position from the car state machine.
REQ-007 SHALL have input car_idle, 1 bit: car stationary, not moving.
REQ-008 SHALL have output target_floor, 4 bits: registered floor the car is sent to.
REQ-009 SHALL have output target_valid, 1 bit: target_floor is a live command.
REQ-010 SHALL have output pending, NUM_FLOORS bits: registered outstanding-request mask.
REQ-011 SHALL have output dir_up, 1 bit: current sweep direction, 1 = up.
REQ-012 SHALL have output door_open, 1 bit: high throughout the door dwell.

Function
REQ-013 SHALL implement FSM states IDLE, SELECT, TRAVEL, DOOR, all outputs registered.
REQ-014 pending bit n SHALL be set the cycle after call_req[n] is sampled high, except per REQ-021.
REQ-015 IDLE: pending == 0 -> stay; pending != 0 -> SELECT next cycle.
REQ-016 SELECT (exactly 1 cycle) SHALL pick target by SCAN: pending bit at current_floor first (dir unchanged); else if dir_up, nearest pending floor above, else nearest below with dir_up cleared; mirror for dir_up = 0 (nearest below, else nearest above with dir_up set).
REQ-017 SELECT SHALL register target_floor and set target_valid = 1, entering TRAVEL; target visible one cycle after SELECT.
REQ-018 TRAVEL: if a request arrives for a floor strictly between current_floor and target_floor in the dir_up direction, target_floor SHALL update to that floor the next cycle; target_valid stays 1.
REQ-019 TRAVEL -> DOOR when car_idle == 1 and current_floor == target_floor; same edge: target_valid <= 0, pending[target_floor] <= 0, door counter loads DOOR_CYCLES-1.
REQ-020 DOOR: door_open = 1; counter decrements each cycle; at 0 -> SELECT if pending != 0, else IDLE; door_open deasserts on that transition.
REQ-021 A call_req for current_floor while in DOOR SHALL be discarded (no pending set, no dwell extension).
REQ-022 Simultaneous set of one pending bit and clear of another SHALL both take effect; set and clear of the same bit in one cycle SHALL resolve to clear.
REQ-023 current_floor >= NUM_FLOORS SHALL be treated as above all floors (only downward targets selectable).
REQ-024 target_floor SHALL hold its last value when target_valid = 0.
REQ-025 Door counter SHALL be 24 bits, no wrap: never decremented below 0.

Reset
REQ-026 On reset: state IDLE, pending = 0, target_floor = 0, target_valid = 0, dir_up = 1, door_open = 0, counter = 0.
REQ-027 Reset asserted mid-TRAVEL or mid-DOOR SHALL abort immediately and discard all pending requests; first SELECT at least 2 cycles after release if a request is applied.

Verification (DOOR_CYCLES = 4)
REQ-028 reset release, current_floor = 0, pulse call_req[3] -> pending = 0x008 next cycle, SELECT, target_floor = 3, target_valid = 1, dir_up = 1.
REQ-029 car at floor 0 travelling to 7, call_req[4] pulsed while current_floor = 2 -> target_floor becomes 4; at car_idle, floor 4: door_open high exactly 4 cycles, pending[4] cleared, then target 7.
REQ-030 current_floor = 5, dir_up = 1, pending = {2, 8} -> target 8 first, then 2 with dir_up = 0.
REQ-031 During DOOR at floor 3, call_req[3] pulsed -> pending[3] stays 0, door_open still exactly 4 cycles.
REQ-032 Reset asserted in DOOR with pending = {1, 6} -> all outputs at reset values same cycle, pending = 0 after release.
REQ-033 Same-cycle call_req[target_floor] and arrival (car_idle, floor match) -> pending[target_floor] = 0 after the edge.

Source files
------------

// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: latches floor calls and serves them
// in SCAN order, commanding the car and timing the door dwell.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS  = 10,
    parameter int DOOR_CYCLES = 10000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [3:0]            current_floor,
    input  logic                  car_idle,
    output logic [3:0]            target_floor,
    output logic                  target_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  door_open
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        TRAVEL,
        DOOR
    } state_t;

    localparam logic [23:0] DOOR_LOAD = 24'(DOOR_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [NUM_FLOORS-1:0] pending_nxt;
    logic [3:0]            target_nxt;
    logic                  valid_nxt;
    logic                  dir_nxt;
    logic                  door_nxt;
    logic [23:0]           cnt;
    logic [23:0]           cnt_nxt;

    logic                  here_hit;
    logic                  above_hit;
    logic                  below_hit;
    logic [3:0]            above_fl;
    logic [3:0]            below_fl;
    logic                  mid_hit;
    logic [3:0]            mid_fl;
    logic                  arrive;
    logic [NUM_FLOORS-1:0] accept;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [4:0]            cur5;
    logic [4:0]            tgt5;

    // Floors at or beyond NUM_FLOORS compare as above every served floor
    assign cur5   = {1'b0, current_floor};
    assign tgt5   = {1'b0, target_floor};
    assign arrive = (state == TRAVEL) && car_idle
                    && (current_floor == target_floor);

    // Nearest outstanding floor above, below and at the car position
    always_comb begin
        here_hit  = 1'b0;
        above_hit = 1'b0;
        below_hit = 1'b0;
        above_fl  = '0;
        below_fl  = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (5'(i) > cur5)) begin
                above_hit = 1'b1;
                above_fl  = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (5'(i) < cur5)) begin
                below_hit = 1'b1;
                below_fl  = 4'(i);
            end
            if (pending[i] && (5'(i) == cur5)) begin
                here_hit = 1'b1;
            end
        end
    end

    // New call closest to the car lying on the way to the current target
    always_comb begin
        mid_hit = 1'b0;
        mid_fl  = target_floor;
        if (dir_up) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (call_req[i] && (5'(i) > cur5) && (5'(i) < tgt5)) begin
                    mid_hit = 1'b1;
                    mid_fl  = 4'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (call_req[i] && (5'(i) < cur5) && (5'(i) > tgt5)) begin
                    mid_hit = 1'b1;
                    mid_fl  = 4'(i);
                end
            end
        end
    end

    // Request mask update: door-floor calls dropped, clear beats set
    always_comb begin
        accept     = '0;
        clear_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            accept[i]     = call_req[i]
                            && !((state == DOOR) && (5'(i) == cur5));
            clear_mask[i] = arrive && (5'(i) == tgt5);
        end
        pending_nxt = (pending | accept) & ~clear_mask;
    end

    // Next state and next values of all registered outputs
    always_comb begin
        state_nxt  = state;
        target_nxt = target_floor;
        valid_nxt  = target_valid;
        dir_nxt    = dir_up;
        door_nxt   = door_open;
        cnt_nxt    = cnt;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                state_nxt = TRAVEL;
                valid_nxt = 1'b1;
                if (here_hit) begin
                    target_nxt = current_floor;
                end else if (dir_up && above_hit) begin
                    target_nxt = above_fl;
                end else if (dir_up && below_hit) begin
                    target_nxt = below_fl;
                    dir_nxt    = 1'b0;
                end else if (!dir_up && below_hit) begin
                    target_nxt = below_fl;
                end else if (!dir_up && above_hit) begin
                    target_nxt = above_fl;
                    dir_nxt    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            TRAVEL: begin
                if (arrive) begin
                    state_nxt = DOOR;
                    valid_nxt = 1'b0;
                    door_nxt  = 1'b1;
                    cnt_nxt   = DOOR_LOAD;
                end else if (mid_hit) begin
                    target_nxt = mid_fl;
                end
            end
            DOOR: begin
                if (cnt == '0) begin
                    door_nxt  = 1'b0;
                    state_nxt = (|pending) ? SELECT : IDLE;
                end else begin
                    cnt_nxt = cnt - 24'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
            cnt          <= '0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            target_floor <= target_nxt;
            target_valid <= valid_nxt;
            dir_up       <= dir_nxt;
            door_open    <= door_nxt;
            cnt          <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed car scenarios,
// a behavioural SCAN model checked every cycle, plus literal pins.
module tb_elevator_request_scheduler;

    localparam int NF = 10;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] call_req = '0;
    logic [3:0]    current_floor = '0;
    logic          car_idle = 1'b1;
    logic [3:0]    target_floor;
    logic          target_valid;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          door_open;

    int tests = 0;
    int fails = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS (NF),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .current_floor(current_floor),
        .car_idle     (car_idle),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .pending      (pending),
        .dir_up       (dir_up),
        .door_open    (door_open)
    );

    always #5 clk = ~clk;

    // Model phases: 0 waiting, 1 choosing, 2 moving, 3 door dwell
    typedef struct {
        int            ph;
        logic [NF-1:0] pend;
        int            tgt;
        bit            vld;
        bit            up;
        bit            door;
        int            left;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mreset();
        mstate_t r;
        r.ph   = 0;
        r.pend = '0;
        r.tgt  = 0;
        r.vld  = 0;
        r.up   = 1;
        r.door = 0;
        r.left = 0;
        return r;
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [NF-1:0] cr,
                                      int cf, bit idle);
        mstate_t       n = s;
        logic [NF-1:0] req = cr;
        int            pick = -1;
        int            best = -1;
        bit            up = s.up;
        int            f;
        if (s.ph == 3 && cf < NF) req[cf] = 1'b0;
        n.pend = s.pend | req;
        case (s.ph)
            0: if (s.pend != '0) n.ph = 1;
            1: begin
                if (cf < NF && s.pend[cf]) begin
                    pick = cf;
                end else begin
                    for (int pass = 0; pass < 2 && pick < 0; pass++) begin
                        for (int d = 1; d <= 16 && pick < 0; d++) begin
                            f = up ? cf + d : cf - d;
                            if (f >= 0 && f < NF && s.pend[f]) pick = f;
                        end
                        if (pick < 0) up = !up;
                    end
                    n.up = up;
                end
                if (pick >= 0) begin
                    n.tgt = pick;
                    n.vld = 1;
                    n.ph  = 2;
                end else begin
                    n.ph = 0;
                end
            end
            2: begin
                if (idle && cf == s.tgt) begin
                    n.ph   = 3;
                    n.vld  = 0;
                    n.door = 1;
                    n.left = DC;
                    n.pend[s.tgt] = 1'b0;
                end else begin
                    for (int d = 1; d < 16; d++) begin
                        f = s.up ? cf + d : cf - d;
                        if (best < 0 && f >= 0 && f < NF
                            && (s.up ? f < s.tgt : f > s.tgt) && cr[f])
                            best = f;
                    end
                    if (best >= 0) n.tgt = best;
                end
            end
            default: begin
                if (s.left <= 1) begin
                    n.door = 0;
                    n.ph   = (s.pend != '0) ? 1 : 0;
                end else begin
                    n.left = s.left - 1;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mreset();
        else m <= mstep(m, call_req, int'(current_floor), car_idle);
    end

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Every cycle, 2 time units after the edge, DUT versus model
    initial begin
        #2;
        forever begin
            @(posedge clk);
            #2;
            chk("cyc_target", int'(target_floor), m.tgt);
            chk("cyc_valid", int'(target_valid), int'(m.vld));
            chk("cyc_pending", int'(pending), int'(m.pend));
            chk("cyc_dir_up", int'(dir_up), int'(m.up));
            chk("cyc_door", int'(door_open), int'(m.door));
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(int floor);
        @(negedge clk);
        reset = 1'b1;
        call_req = '0;
        current_floor = 4'(floor);
        car_idle = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(logic [NF-1:0] bits);
        call_req = bits;
        tick(1);
        call_req = '0;
    endtask

    task automatic measure_door(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (door_open) n++;
            else if (n > 0) break;
            @(negedge clk);
            call_req = '0;
        end
    endtask

    task automatic wait_valid(string name);
        int k = 0;
        while (!target_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(target_valid), 1);
    endtask

    int dn;

    initial begin
        #1 reset = 1'b1;
        tick(1);
        chk("reset_target", int'(target_floor), 0);
        chk("reset_valid", int'(target_valid), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_dir", int'(dir_up), 1);
        chk("reset_door", int'(door_open), 0);
        reset = 1'b0;

        // first call from floor 0, then door call discarded
        current_floor = 4'd0;
        tick(1);
        pulse(10'h008);
        chk("s1_pending", int'(pending), 8);
        tick(2);
        chk("s1_target", int'(target_floor), 3);
        chk("s1_valid", int'(target_valid), 1);
        chk("s1_dir", int'(dir_up), 1);
        current_floor = 4'd3;
        tick(1);
        chk("s1_door_on", int'(door_open), 1);
        call_req = 10'h008;
        measure_door(dn);
        chk("s1_door_len", dn, 4);
        chk("s1_pending_after", int'(pending), 0);

        // intermediate call reroutes the car, then resumes to 7
        do_reset(0);
        pulse(10'h080);
        tick(2);
        chk("s2_target7", int'(target_floor), 7);
        current_floor = 4'd1;
        car_idle = 1'b0;
        tick(1);
        current_floor = 4'd2;
        call_req = 10'h010;
        tick(1);
        call_req = '0;
        current_floor = 4'd3;
        chk("s2_target4", int'(target_floor), 4);
        chk("s2_pending", int'(pending), 'h090);
        tick(1);
        current_floor = 4'd4;
        car_idle = 1'b1;
        tick(1);
        measure_door(dn);
        chk("s2_door_len", dn, 4);
        chk("s2_pending4_clr", int'(pending), 'h080);
        wait_valid("s2_valid7");
        chk("s2_target7b", int'(target_floor), 7);

        // sweep up to 8 first, then reverse down to 2
        do_reset(5);
        pulse(10'h104);
        chk("s3_pending", int'(pending), 'h104);
        tick(2);
        chk("s3_target8", int'(target_floor), 8);
        chk("s3_dir_up", int'(dir_up), 1);
        current_floor = 4'd8;
        tick(1);
        measure_door(dn);
        chk("s3_door_len", dn, 4);
        wait_valid("s3_valid2");
        chk("s3_target2", int'(target_floor), 2);
        chk("s3_dir_down", int'(dir_up), 0);
        current_floor = 4'd2;
        tick(1);
        measure_door(dn);
        chk("s3_door_len2", dn, 4);

        // car beyond the top floor: only downward targets
        do_reset(12);
        pulse(10'h010);
        tick(2);
        chk("s4_target4", int'(target_floor), 4);
        chk("s4_dir_down", int'(dir_up), 0);

        // arrival with same-floor call plus another floor call
        do_reset(0);
        pulse(10'h008);
        tick(2);
        current_floor = 4'd3;
        call_req = 10'h028;
        tick(1);
        call_req = '0;
        chk("s5_pending", int'(pending), 'h020);
        chk("s5_door", int'(door_open), 1);
        measure_door(dn);
        chk("s5_door_len", dn, 4);
        wait_valid("s5_valid5");
        chk("s5_target5", int'(target_floor), 5);

        // reset in the middle of a door dwell
        do_reset(2);
        pulse(10'h004);
        tick(3);
        chk("s6_door", int'(door_open), 1);
        pulse(10'h042);
        chk("s6_pending", int'(pending), 'h042);
        reset = 1'b1;
        #1;
        chk("s6_rst_target", int'(target_floor), 0);
        chk("s6_rst_valid", int'(target_valid), 0);
        chk("s6_rst_pending", int'(pending), 0);
        chk("s6_rst_dir", int'(dir_up), 1);
        chk("s6_rst_door", int'(door_open), 0);
        tick(1);
        reset = 1'b0;
        tick(2);
        chk("s6_pending_after", int'(pending), 0);
        chk("s6_valid_after", int'(target_valid), 0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
